apb_slave_regfile: RTL and testbench

// - APB completer (slave) answering the APB master's PSEL/PENABLE/PWRITE/PADDR/PWDATA transfers.
// - Holds NUM_REGS word registers; register 0 is a read-only ID.
// - Inserts WAIT_CYCLES wait states per access.
// - Flags bad accesses with PSLVERR.
// - Sits on the peripheral side of the APB bus; register contents are exported flat to local logic.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_if.sv | 24 ++
 rtl/apb_reg_bank.sv | 44 ++++
 rtl/apb_slave_regfile.sv | 137 +++++++++++++
 tb/tb_apb_slave_regfile.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB completer/requester definitions: slave FSM states, register address LSB and
// error codes.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_slv_state_t;

  localparam int unsigned ADDR_LSB = 2;

  localparam int unsigned ERR_W = 2;
  localparam logic [ERR_W-1:0] ERR_NONE     = 2'd0;
  localparam logic [ERR_W-1:0] ERR_MISALIGN = 2'd1;
  localparam logic [ERR_W-1:0] ERR_RANGE    = 2'd2;
  localparam logic [ERR_W-1:0] ERR_RDONLY   = 2'd3;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle with requester (master) and completer (slave) views.
interface apb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_reg_bank.sv
// Word register bank: register 0 is a constant ID, the rest are writable flops with one
// write port and a combinational read mux.
module apb_reg_bank #(
    parameter int unsigned          NUM_REGS = 16,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          IDX_W    = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0]    ID_VALUE = 32'hA9B0_0001
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       we_i,
    input  logic [IDX_W-1:0]           widx_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [IDX_W-1:0]           ridx_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);

    logic [DATA_W-1:0] store_q [1:NUM_REGS-1];

    always_ff @(posedge clk_i) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rst_i) begin
                store_q[i] <= '0;
            end else if (we_i && (int'(widx_i) == i)) begin
                store_q[i] <= wdata_i;
            end
        end
    end

    // Indices beyond NUM_REGS-1 fall back to the ID; the caller flags them as errors anyway.
    always_comb begin
        rdata_o = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (int'(ridx_i) == i) rdata_o = store_q[i];
        end
    end

    assign regs_o[0 +: DATA_W] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_W +: DATA_W] = store_q[g];
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer fronting a small register file, with configurable wait states and
// PSLVERR on misaligned, out-of-range or read-only accesses. All outputs are registered.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       NUM_REGS    = 16,
    parameter int unsigned       WAIT_CYCLES = 0,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    apb_if.slave                       bus,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_pulse
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam int unsigned CNT_W = 4;

    apb_slv_state_t    state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] prdata_q;
    logic              wr_pulse_q;

    logic [ERR_W-1:0]  err_code;
    logic              setup_err;
    logic [IDX_W-1:0]  setup_idx;
    logic [DATA_W-1:0] bank_rdata;
    logic [DATA_W-1:0] setup_rdata;
    logic [ADDR_W-1:0] word_addr;
    logic              commit;

    assign word_addr = bus.PADDR >> ADDR_LSB;
    assign setup_idx = bus.PADDR[ADDR_LSB +: IDX_W];

    always_comb begin
        err_code = ERR_NONE;
        if (bus.PADDR[ADDR_LSB-1:0] != '0) begin
            err_code = ERR_MISALIGN;
        end else if (word_addr >= ADDR_W'(NUM_REGS)) begin
            err_code = ERR_RANGE;
        end else if (bus.PWRITE && (word_addr == '0)) begin
            err_code = ERR_RDONLY;
        end
    end

    assign setup_err   = (err_code != ERR_NONE);
    // Read data is captured at setup; writes and errors return zero.
    assign setup_rdata = (!bus.PWRITE && !setup_err) ? bank_rdata : '0;
    assign commit      = (state_q == RESP) && bus.PSEL && bus.PENABLE && bus.PWRITE && !err_q;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= 1'b0;
        end else begin
            wr_pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.PSEL && !bus.PENABLE) begin
                        idx_q   <= setup_idx;
                        wdata_q <= bus.PWDATA;
                        rdata_q <= setup_rdata;
                        err_q   <= setup_err;
                        if (WAIT_CYCLES == 0) begin
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= setup_err;
                            prdata_q  <= setup_rdata;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!bus.PSEL) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q;
                        prdata_q  <= rdata_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    pready_q   <= 1'b0;
                    pslverr_q  <= 1'b0;
                    prdata_q   <= '0;
                    wr_pulse_q <= commit;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .we_i    (commit),
        .widx_i  (idx_q),
        .wdata_i (wdata_q),
        .ridx_i  (setup_idx),
        .rdata_o (bank_rdata),
        .regs_o  (regs_o)
    );

    assign bus.PREADY  = pready_q;
    assign bus.PSLVERR = pslverr_q;
    assign bus.PRDATA  = prdata_q;
    assign wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 3 and 4 wait states) checked against an
// array-based register model with directed and randomized APB transfers.
module tb_apb_slave_regfile;

    localparam int NR = 16;
    localparam int DW = 32;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    int          cur;

    int checks   = 0;
    int failures = 0;

    int          wcfg [3] = '{0, 3, 4};
    logic [31:0] mregs [3][NR];

    apb_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    apb_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    apb_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    assign bus0.PSEL = psel && (cur == 0);
    assign bus1.PSEL = psel && (cur == 1);
    assign bus2.PSEL = psel && (cur == 2);
    assign bus0.PENABLE = penable;
    assign bus1.PENABLE = penable;
    assign bus2.PENABLE = penable;
    assign bus0.PWRITE = pwrite;
    assign bus1.PWRITE = pwrite;
    assign bus2.PWRITE = pwrite;
    assign bus0.PADDR = paddr;
    assign bus1.PADDR = paddr;
    assign bus2.PADDR = paddr;
    assign bus0.PWDATA = pwdata;
    assign bus1.PWDATA = pwdata;
    assign bus2.PWDATA = pwdata;

    logic [NR*DW-1:0] regs0, regs1, regs2;
    logic             wrp0, wrp1, wrp2;

    apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut0 (
        .PCLK(clk), .PRESET(rst), .bus(bus0), .regs_o(regs0), .wr_pulse(wrp0));
    apb_slave_regfile #(.WAIT_CYCLES(3)) u_dut1 (
        .PCLK(clk), .PRESET(rst), .bus(bus1), .regs_o(regs1), .wr_pulse(wrp1));
    apb_slave_regfile #(.WAIT_CYCLES(4)) u_dut2 (
        .PCLK(clk), .PRESET(rst), .bus(bus2), .regs_o(regs2), .wr_pulse(wrp2));

    logic             o_rdy, o_err, o_wrp;
    logic [31:0]      o_rdata;
    logic [NR*DW-1:0] o_regs;

    always_comb begin
        case (cur)
            0: begin
                o_rdy = bus0.PREADY; o_err = bus0.PSLVERR; o_rdata = bus0.PRDATA;
                o_wrp = wrp0; o_regs = regs0;
            end
            1: begin
                o_rdy = bus1.PREADY; o_err = bus1.PSLVERR; o_rdata = bus1.PRDATA;
                o_wrp = wrp1; o_regs = regs1;
            end
            default: begin
                o_rdy = bus2.PREADY; o_err = bus2.PSLVERR; o_rdata = bus2.PRDATA;
                o_wrp = wrp2; o_regs = regs2;
            end
        endcase
    end

    function automatic logic exp_err(input logic wr, input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(NR)) || (wr && ((a >> 2) == 32'd0));
    endfunction

    function automatic logic [NR*DW-1:0] model_flat(input int c);
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = mregs[c][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < NR; i++) mregs[c][i] = (i == 0) ? ID : 32'd0;
    endtask

    // Called at the start of a cycle; returns in the cycle after the response with the bus idle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic se, output int waits,
                        output logic wp, output logic low_zero);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1; waits = 0; low_zero = 1'b1;
        while (!o_rdy && waits < 40) begin
            if (o_rdata !== 32'd0 || o_err !== 1'b0) low_zero = 1'b0;
            @(posedge clk); #1;
            waits++;
        end
        rd = o_rdata; se = o_err;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        wp = o_wrp;
    endtask

    logic [31:0] rd;
    logic        se, wp, lz;
    int          wt;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            cur = k; #1;
            checks++;
            if ({o_rdy, o_err, o_wrp, o_rdata} !== 35'd0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got rdy=%b err=%b wrp=%b rdata=%h want 0",
                         k, o_rdy, o_err, o_wrp, o_rdata);
            end
            checks++;
            if (o_regs !== model_flat(k)) begin
                failures++;
                $display("FAIL reset_regs dut=%0d got %h want %h", k, o_regs, model_flat(k));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_id_read();
        cur = 0;
        xfer(1'b0, 32'h00, 32'h0, rd, se, wt, wp, lz);
        checks++;
        if (wt !== 0 || rd !== ID || se !== 1'b0) begin
            failures++;
            $display("FAIL id_read got waits=%0d rdata=%h err=%b want 0 %h 0", wt, rd, se, ID);
        end
    endtask

    task automatic test_write_read();
        cur = 0;
        xfer(1'b1, 32'h04, 32'hDEADBEEF, rd, se, wt, wp, lz);
        mregs[0][1] = 32'hDEADBEEF;
        checks++;
        if (wp !== 1'b1 || se !== 1'b0 || rd !== 32'd0) begin
            failures++;
            $display("FAIL write04 got wrp=%b err=%b rdata=%h want 1 0 0", wp, se, rd);
        end
        checks++;
        if (o_regs[63:32] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL regs_o_reg1 got %h want deadbeef", o_regs[63:32]);
        end
        @(posedge clk); #1;
        checks++;
        if (o_wrp !== 1'b0) begin
            failures++;
            $display("FAIL wr_pulse_single got %b want 0", o_wrp);
        end
        xfer(1'b0, 32'h04, 32'h0, rd, se, wt, wp, lz);
        checks++;
        if (rd !== 32'hDEADBEEF || se !== 1'b0 || wp !== 1'b0) begin
            failures++;
            $display("FAIL read04 got rdata=%h err=%b wrp=%b want deadbeef 0 0", rd, se, wp);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] v;
        cur = 1;
        v = $urandom;
        xfer(1'b1, 32'h08, v, rd, se, wt, wp, lz);
        mregs[1][2] = v;
        checks++;
        if (wt !== 3 || lz !== 1'b1 || wp !== 1'b1 || se !== 1'b0) begin
            failures++;
            $display("FAIL wait3_write got waits=%0d lowzero=%b wrp=%b err=%b want 3 1 1 0",
                     wt, lz, wp, se);
        end
        xfer(1'b0, 32'h08, 32'h0, rd, se, wt, wp, lz);
        checks++;
        if (wt !== 3 || rd !== v) begin
            failures++;
            $display("FAIL wait3_read got waits=%0d rdata=%h want 3 %h", wt, rd, v);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3] = '{32'h40, 32'h00, 32'h06};
        logic        wrs   [3] = '{1'b1, 1'b1, 1'b0};
        cur = 0;
        for (int i = 0; i < 3; i++) begin
            xfer(wrs[i], addrs[i], 32'h5A5A_1234, rd, se, wt, wp, lz);
            checks++;
            if (se !== 1'b1 || rd !== 32'd0 || wp !== 1'b0) begin
                failures++;
                $display("FAIL err_%h got err=%b rdata=%h wrp=%b want 1 0 0", addrs[i], se, rd, wp);
            end
            checks++;
            if (o_regs !== model_flat(0)) begin
                failures++;
                $display("FAIL err_regs_%h got %h want %h", addrs[i], o_regs, model_flat(0));
            end
        end
        cur = 1;
        xfer(1'b0, 32'h44, 32'h0, rd, se, wt, wp, lz);
        checks++;
        if (se !== 1'b1 || rd !== 32'd0 || wt !== 3) begin
            failures++;
            $display("FAIL err_wait3 got err=%b rdata=%h waits=%0d want 1 0 3", se, rd, wt);
        end
    endtask

    task automatic test_back_to_back();
        cur = 0;
        xfer(1'b1, 32'h0C, 32'h1, rd, se, wt, wp, lz);
        mregs[0][3] = 32'h1;
        xfer(1'b0, 32'h0C, 32'h0, rd, se, wt, wp, lz);
        checks++;
        if (wt !== 0 || rd !== 32'h1 || se !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back got waits=%0d rdata=%h err=%b want 0 1 0", wt, rd, se);
        end
    endtask

    task automatic test_abort_psel();
        logic [31:0] a;
        logic        bad;
        cur = 2;
        a = $urandom;
        xfer(1'b1, 32'h10, a, rd, se, wt, wp, lz);
        mregs[2][4] = a;
        checks++;
        if (wt !== 4 || wp !== 1'b1) begin
            failures++;
            $display("FAIL wait4_write got waits=%0d wrp=%b want 4 1", wt, wp);
        end
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = ~a;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (o_rdy !== 1'b0 || o_wrp !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || o_regs !== model_flat(2)) begin
            failures++;
            $display("FAIL abort_psel got stray=%b regs=%h want 0 %h", bad, o_regs, model_flat(2));
        end
        xfer(1'b0, 32'h10, 32'h0, rd, se, wt, wp, lz);
        checks++;
        if (wt !== 4 || rd !== a) begin
            failures++;
            $display("FAIL abort_psel_read got waits=%0d rdata=%h want 4 %h", wt, rd, a);
        end
    endtask

    task automatic test_abort_reset();
        cur = 2;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hCAFE_F00D;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
        model_reset();
        checks++;
        if ({o_rdy, o_err, o_wrp, o_rdata} !== 35'd0 || o_regs !== model_flat(2)) begin
            failures++;
            $display("FAIL abort_reset got rdy=%b err=%b wrp=%b rdata=%h regs=%h want all 0/reset",
                     o_rdy, o_err, o_wrp, o_rdata, o_regs);
        end
        xfer(1'b0, 32'h14, 32'h0, rd, se, wt, wp, lz);
        checks++;
        if (wt !== 4 || rd !== 32'd0 || se !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset_read got waits=%0d rdata=%h err=%b want 4 0 0", wt, rd, se);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, erd;
        logic        w, ee;
        int          r;
        for (int k = 0; k < 3; k++) begin
            cur = k;
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r < 6)      a = 32'($urandom_range(0, NR - 1)) << 2;
                else if (r < 8) a = (32'($urandom_range(0, NR - 1)) << 2) | 32'($urandom_range(1, 3));
                else            a = 32'($urandom_range(NR, 4000)) << 2;
                w  = 1'($urandom_range(0, 1));
                d  = $urandom;
                ee = exp_err(w, a);
                erd = (!w && !ee) ? mregs[k][a[5:2]] : 32'd0;
                xfer(w, a, d, rd, se, wt, wp, lz);
                if (w && !ee) mregs[k][a[5:2]] = d;
                checks++;
                if (se !== ee || rd !== erd || wt !== wcfg[k] || wp !== (w && !ee) || lz !== 1'b1) begin
                    failures++;
                    $display("FAIL rand dut=%0d wr=%b addr=%h got err=%b rdata=%h waits=%0d wrp=%b lowzero=%b want %b %h %0d %b 1",
                             k, w, a, se, rd, wt, wp, lz, ee, erd, wcfg[k], w && !ee);
                end
                checks++;
                if (o_regs !== model_flat(k)) begin
                    failures++;
                    $display("FAIL rand_regs dut=%0d got %h want %h", k, o_regs, model_flat(k));
                end
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    initial begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        cur = 0; rst = 1'b1;
        test_reset();
        test_id_read();
        test_write_read();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_abort_psel();
        test_abort_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
